// File: rtl/axi4_lite_7seg.sv
// AXI4-Lite slave that drives eight active-low 7-segment digits.
// Registers: CTRL (0x00), DIGITS (0x04), RAW_LO (0x08), RAW_HI (0x0C).
// Optional feature macro AXI4_LITE_7SEG_ID_EN adds a read-only ID register at 0x10.
module axi4_lite_7seg #(
  parameter int G_AXI4_LITE_ADDR_WIDTH = 8,
  parameter int G_AXI4_LITE_DATA_WIDTH = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  awvalid,
  input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0]     awaddr,
  input  logic [2:0]                            awprot,
  output logic                                  awready,
  input  logic                                  wvalid,
  input  logic [G_AXI4_LITE_DATA_WIDTH-1:0]     wdata,
  input  logic [G_AXI4_LITE_DATA_WIDTH/8-1:0]   wstrb,
  output logic                                  wready,
  input  logic                                  bready,
  output logic                                  bvalid,
  output logic [1:0]                            bresp,
  input  logic                                  arvalid,
  input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0]     araddr,
  input  logic [2:0]                            arprot,
  output logic                                  arready,
  input  logic                                  rready,
  output logic                                  rvalid,
  output logic [G_AXI4_LITE_DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                            rresp,
  output logic [6:0]                            o_seg0,
  output logic [6:0]                            o_seg1,
  output logic [6:0]                            o_seg2,
  output logic [6:0]                            o_seg3,
  output logic [6:0]                            o_seg4,
  output logic [6:0]                            o_seg5,
  output logic [6:0]                            o_seg6,
  output logic [6:0]                            o_seg7
);

  localparam int AW = G_AXI4_LITE_ADDR_WIDTH;
  localparam int DW = G_AXI4_LITE_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int IW = AW - 2;

  localparam logic [IW-1:0] IDX_CTRL   = IW'(0);
  localparam logic [IW-1:0] IDX_DIGITS = IW'(1);
  localparam logic [IW-1:0] IDX_RAW_LO = IW'(2);
  localparam logic [IW-1:0] IDX_RAW_HI = IW'(3);
  localparam logic [IW-1:0] IDX_ID     = IW'(4);

  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;
  localparam logic [DW-1:0] ID_VALUE    = DW'(32'h75E6_0001);
  localparam logic [6:0]    SEG_BLANK   = 7'h7F;

`ifdef AXI4_LITE_7SEG_ID_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  // Hex nibble to active-low segment pattern (bit0 = a .. bit6 = g).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Byte-lane merge of new write data into an existing register value.
  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old_v;
    for (int i = 0; i < SW; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  logic [DW-1:0] ctrl_q,   ctrl_d;
  logic [DW-1:0] digits_q, digits_d;
  logic [DW-1:0] raw_lo_q, raw_lo_d;
  logic [DW-1:0] raw_hi_q, raw_hi_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q,  bresp_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q,  rdata_d;
  logic [1:0]    rresp_q,  rresp_d;
  logic [6:0]    seg_q [8];
  logic [6:0]    seg_d [8];

  logic          wr_fire;
  logic          rd_fire;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [2*DW-1:0] raw_all;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

  // AW and W are taken together, only while no write response is pending.
  assign wr_fire = awvalid & wvalid & ~bvalid_q & ~rst;
  assign rd_fire = arvalid & ~rvalid_q & ~rst;
  assign wr_idx  = awaddr[AW-1:2];
  assign rd_idx  = araddr[AW-1:2];
  assign raw_all = {raw_hi_q, raw_lo_q};

  assign awready = wr_fire;
  assign wready  = wr_fire;
  assign arready = rd_fire;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  // Write channel: register update on the accept cycle and response tracking.
  always_comb begin
    ctrl_d   = ctrl_q;
    digits_d = digits_q;
    raw_lo_d = raw_lo_q;
    raw_hi_d = raw_hi_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (bvalid_q && bready) bvalid_d = 1'b0;
    if (wr_fire) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_OKAY;
      case (wr_idx)
        IDX_CTRL:   ctrl_d   = apply_strb(ctrl_q,   wdata, wstrb);
        IDX_DIGITS: digits_d = apply_strb(digits_q, wdata, wstrb);
        IDX_RAW_LO: raw_lo_d = apply_strb(raw_lo_q, wdata, wstrb);
        IDX_RAW_HI: raw_hi_d = apply_strb(raw_hi_q, wdata, wstrb);
        IDX_ID:     if (!ID_EN) bresp_d = RESP_SLVERR;
        default:    bresp_d = RESP_SLVERR;
      endcase
    end
  end

  // Read channel: capture data/response on the accept cycle, hold until rready.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && rready) rvalid_d = 1'b0;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      case (rd_idx)
        IDX_CTRL:   rdata_d = ctrl_q;
        IDX_DIGITS: rdata_d = digits_q;
        IDX_RAW_LO: rdata_d = raw_lo_q;
        IDX_RAW_HI: rdata_d = raw_hi_q;
        IDX_ID: begin
          if (ID_EN) begin
            rdata_d = ID_VALUE;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
        end
        default: begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
        end
      endcase
    end
  end

  // Display selection: blank, raw pattern, or decoded nibble per digit.
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      if (!ctrl_q[0])     seg_d[n] = SEG_BLANK;
      else if (ctrl_q[1]) seg_d[n] = raw_all[8*n +: 7];
      else                seg_d[n] = hex_to_seg(digits_q[4*n +: 4]);
    end
  end

  // State registers; reset drops any in-flight response and blanks the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      digits_q <= '0;
      raw_lo_q <= '0;
      raw_hi_q <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
      for (int n = 0; n < 8; n++) seg_q[n] <= SEG_BLANK;
    end else begin
      ctrl_q   <= ctrl_d;
      digits_q <= digits_d;
      raw_lo_q <= raw_lo_d;
      raw_hi_q <= raw_hi_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      for (int n = 0; n < 8; n++) seg_q[n] <= seg_d[n];
    end
  end

  assign o_seg0 = seg_q[0];
  assign o_seg1 = seg_q[1];
  assign o_seg2 = seg_q[2];
  assign o_seg3 = seg_q[3];
  assign o_seg4 = seg_q[4];
  assign o_seg5 = seg_q[5];
  assign o_seg6 = seg_q[6];
  assign o_seg7 = seg_q[7];

endmodule

// File: tb/tb_axi4_lite_7seg.sv
// Directed testbench for axi4_lite_7seg with hand-computed expectations.
module tb_axi4_lite_7seg;

  logic        clk;
  logic        rst;
  logic        awvalid;
  logic [7:0]  awaddr;
  logic [2:0]  awprot;
  logic        awready;
  logic        wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wready;
  logic        bready;
  logic        bvalid;
  logic [1:0]  bresp;
  logic        arvalid;
  logic [7:0]  araddr;
  logic [2:0]  arprot;
  logic        arready;
  logic        rready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [6:0]  seg [8];

  int n_cmp;
  int n_err;

  axi4_lite_7seg #(
    .G_AXI4_LITE_ADDR_WIDTH(8),
    .G_AXI4_LITE_DATA_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awaddr(awaddr), .awprot(awprot), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bready(bready), .bvalid(bvalid), .bresp(bresp),
    .arvalid(arvalid), .araddr(araddr), .arprot(arprot), .arready(arready),
    .rready(rready), .rvalid(rvalid), .rdata(rdata), .rresp(rresp),
    .o_seg0(seg[0]), .o_seg1(seg[1]), .o_seg2(seg[2]), .o_seg3(seg[3]),
    .o_seg4(seg[4]), .o_seg5(seg[5]), .o_seg6(seg[6]), .o_seg7(seg[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full write transaction with bready held high; returns the response.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp,
                           output bit ok);
    int w;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    #1;
    w = 0;
    while (!awready && w < 20) begin @(posedge clk); #1; w++; end
    ok = awready && wready;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    ok = ok && bvalid;
    resp = bresp;
    @(posedge clk); #1;
  endtask

  // Full read transaction with rready held high.
  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output bit ok);
    int w;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    #1;
    w = 0;
    while (!arready && w < 20) begin @(posedge clk); #1; w++; end
    ok = arready;
    @(posedge clk); #1;
    arvalid = 1'b0;
    ok = ok && rvalid;
    data = rdata;
    resp = rresp;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; bit ok;
    logic [7:0] addrs [4];
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C};
    rst = 1'b1;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_handshake: got %b expected 00000",
               {awready, wready, arready, bvalid, rvalid});
    end
    n_cmp++;
    if ({bresp, rresp, rdata} !== 36'h0) begin
      n_err++;
      $display("FAIL reset_resp_data: got bresp=%b rresp=%b rdata=%h expected 0",
               bresp, rresp, rdata);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (seg[i] !== 7'h7F) begin
        n_err++;
        $display("FAIL reset_seg%0d: got %h expected 7f", i, seg[i]);
      end
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      axi_read(addrs[i], d, r, ok);
      n_cmp++;
      if (!ok || d !== 32'h0 || r !== 2'b00) begin
        n_err++;
        $display("FAIL reset_read_%h: got ok=%0d rdata=%h rresp=%b expected 00000000/00",
                 addrs[i], ok, d, r);
      end
    end
  endtask

  task automatic test_hex_decode();
    logic [1:0] r0, r1; bit ok0, ok1;
    logic [6:0] exp_seg [8];
    exp_seg = '{7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    axi_write(8'h04, 32'hFEDC_BA98, 4'hF, r0, ok0);
    axi_write(8'h00, 32'h0000_0001, 4'hF, r1, ok1);
    n_cmp++;
    if (!ok0 || !ok1 || r0 !== 2'b00 || r1 !== 2'b00) begin
      n_err++;
      $display("FAIL hex_bresp: got ok=%0d%0d bresp=%b,%b expected 00,00", ok0, ok1, r0, r1);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (seg[i] !== exp_seg[i]) begin
        n_err++;
        $display("FAIL hex_seg%0d: got %h expected %h", i, seg[i], exp_seg[i]);
      end
    end
  endtask

  task automatic test_raw_mode();
    logic [1:0] r; bit ok;
    logic [6:0] exp_seg [8];
    exp_seg = '{7'h7F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    axi_write(8'h08, 32'h0000_007F, 4'b0001, r, ok);
    axi_write(8'h00, 32'h0000_0003, 4'hF, r, ok);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (seg[i] !== exp_seg[i]) begin
        n_err++;
        $display("FAIL raw_seg%0d: got %h expected %h", i, seg[i], exp_seg[i]);
      end
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic [1:0] r; bit ok;
    logic [6:0] exp_seg [8];
    exp_seg = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h30, 7'h24, 7'h40, 7'h40};
    axi_write(8'h04, 32'h0000_0000, 4'hF, r, ok);
    axi_write(8'h04, 32'h0123_4567, 4'b0100, r, ok);
    axi_read(8'h04, d, r, ok);
    n_cmp++;
    if (!ok || d !== 32'h0023_0000 || r !== 2'b00) begin
      n_err++;
      $display("FAIL strobe_read: got ok=%0d rdata=%h rresp=%b expected 00230000/00", ok, d, r);
    end
    axi_write(8'h00, 32'h0000_0001, 4'hF, r, ok);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (seg[i] !== exp_seg[i]) begin
        n_err++;
        $display("FAIL strobe_seg%0d: got %h expected %h", i, seg[i], exp_seg[i]);
      end
    end
    axi_read(8'h07, d, r, ok);
    n_cmp++;
    if (!ok || d !== 32'h0023_0000 || r !== 2'b00) begin
      n_err++;
      $display("FAIL addr_low_bits: got rdata=%h rresp=%b expected 00230000/00", d, r);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic [1:0] r; bit ok;
    logic [31:0] exp_id; logic [1:0] exp_id_resp;
`ifdef AXI4_LITE_7SEG_ID_EN
    exp_id = 32'h75E6_0001; exp_id_resp = 2'b00;
`else
    exp_id = 32'h0; exp_id_resp = 2'b10;
`endif
    axi_read(8'h14, d, r, ok);
    n_cmp++;
    if (!ok || d !== 32'h0 || r !== 2'b10) begin
      n_err++;
      $display("FAIL unmapped_read: got ok=%0d rdata=%h rresp=%b expected 00000000/10", ok, d, r);
    end
    axi_read(8'h10, d, r, ok);
    n_cmp++;
    if (!ok || d !== exp_id || r !== exp_id_resp) begin
      n_err++;
      $display("FAIL id_read: got rdata=%h rresp=%b expected %h/%b", d, r, exp_id, exp_id_resp);
    end
    awaddr = 8'h18; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    #1;
    n_cmp++;
    if (awready !== 1'b1) begin
      n_err++;
      $display("FAIL unmapped_awready: got %b expected 1", awready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bvalid !== 1'b1 || bresp !== 2'b10) begin
        n_err++;
        $display("FAIL bvalid_hold_%0d: got bvalid=%b bresp=%b expected 1/10", i, bvalid, bresp);
      end
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bvalid !== 1'b0) begin
      n_err++;
      $display("FAIL bvalid_release: got %b expected 0", bvalid);
    end
    axi_read(8'h00, d, r, ok);
    n_cmp++;
    if (d !== 32'h0000_0001) begin
      n_err++;
      $display("FAIL unmapped_ctrl_kept: got %h expected 00000001", d);
    end
    axi_read(8'h08, d, r, ok);
    n_cmp++;
    if (d !== 32'h0000_007F) begin
      n_err++;
      $display("FAIL unmapped_rawlo_kept: got %h expected 0000007f", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] r; bit ok;
    awaddr = 8'h0C; wdata = 32'h1122_3344; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    araddr = 8'h04; arvalid = 1'b1; rready = 1'b1;
    #1;
    n_cmp++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_err++;
      $display("FAIL dual_ready: got %b expected 111", {awready, wready, arready});
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    n_cmp++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== 32'h0023_0000 || bresp !== 2'b00) begin
      n_err++;
      $display("FAIL dual_resp: got bvalid=%b rvalid=%b rdata=%h bresp=%b expected 1/1/00230000/00",
               bvalid, rvalid, rdata, bresp);
    end
    @(posedge clk); #1;
    axi_read(8'h0C, d, r, ok);
    n_cmp++;
    if (!ok || d !== 32'h1122_3344 || r !== 2'b00) begin
      n_err++;
      $display("FAIL dual_write_data: got rdata=%h rresp=%b expected 11223344/00", d, r);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; bit ok;
    awaddr = 8'h04; wdata = 32'hAAAA_AAAA; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    #1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n_cmp++;
    if (bvalid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_bvalid_pending: got %b expected 1", bvalid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bvalid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_bvalid_dropped: got %b expected 0", bvalid);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (seg[i] !== 7'h7F) begin
        n_err++;
        $display("FAIL mid_seg%0d: got %h expected 7f", i, seg[i]);
      end
    end
    rst = 1'b0;
    bready = 1'b1;
    @(posedge clk); #1;
    axi_read(8'h00, d, r, ok);
    n_cmp++;
    if (!ok || d !== 32'h0 || r !== 2'b00) begin
      n_err++;
      $display("FAIL mid_ctrl_cleared: got ok=%0d rdata=%h rresp=%b expected 00000000/00", ok, d, r);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1;
    awvalid = 1'b0; awaddr = '0; awprot = '0;
    wvalid = 1'b0; wdata = '0; wstrb = '0;
    bready = 1'b1;
    arvalid = 1'b0; araddr = '0; arprot = '0;
    rready = 1'b1;
    test_reset();
    test_hex_decode();
    test_raw_mode();
    test_strobe();
    test_unmapped();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
